// File: rtl/wgt_buf_pkg.sv
// Shared definitions for the weight ping-pong feeder.
//   WGT_DATA_W / WGT_ADDR_W / WGT_REP_W : default word, bank-address and repeat widths
//   WGT_FIFO_DEPTH                      : entries in the output skid FIFO
//   feed_state_e                        : feeder sequencing states
package wgt_buf_pkg;

  localparam int unsigned WGT_DATA_W     = 16;
  localparam int unsigned WGT_ADDR_W     = 8;
  localparam int unsigned WGT_REP_W      = 4;
  localparam int unsigned WGT_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DRAIN
  } feed_state_e;

endpackage

// File: rtl/wgt_bank_ram.sv
// Simple dual-port weight bank: one write port, one synchronous read port
// (read data valid the cycle after re).
//   clock        : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request
//   rdata        : registered read data
module wgt_bank_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wgt_pingpong_feeder.sv
// Two-bank ping-pong weight buffer between img2col_weight and the systolic
// array weight loader. img2col fills one bank while the other streams out.
//   clock, rst                         : clock, async active-high reset
//   wgt_wr_en/wgt_wr_addr/wgt_wr_data  : word writes into bank chn_sel
//   chn_sel                            : bank targeted by writes / fill_done
//   fill_done/fill_len                 : bank chn_sel complete, fill_len words (0 = full depth)
//   bank_vld                           : per-bank "full, owned by feeder"
//   feed_start/feed_repeat             : stream next bank, feed_repeat extra passes
//   feed_busy/feed_done                : feed in progress / final word accepted
//   wgt_out_vld/wgt_out/wgt_out_last/wgt_out_rdy : output stream (last per pass)
//   wr_err                             : sticky, write or fill_done hit an owned bank
module wgt_pingpong_feeder
  import wgt_buf_pkg::*;
#(
  parameter int unsigned DATA_W = WGT_DATA_W,
  parameter int unsigned ADDR_W = WGT_ADDR_W,
  parameter int unsigned REP_W  = WGT_REP_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wgt_wr_en,
  input  logic [ADDR_W-1:0] wgt_wr_addr,
  input  logic [DATA_W-1:0] wgt_wr_data,
  input  logic              chn_sel,
  input  logic              fill_done,
  input  logic [ADDR_W:0]   fill_len,
  output logic [1:0]        bank_vld,
  input  logic              feed_start,
  input  logic [REP_W-1:0]  feed_repeat,
  output logic              feed_busy,
  output logic              feed_done,
  output logic              wgt_out_vld,
  output logic [DATA_W-1:0] wgt_out,
  output logic              wgt_out_last,
  input  logic              wgt_out_rdy,
  output logic              wr_err
);

  feed_state_e       state;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [REP_W-1:0]  rep_cnt;
  logic [ADDR_W:0]   bank_len [2];

  logic [1:0]        ram_we;
  logic [1:0]        ram_re;
  logic [DATA_W-1:0] ram_rdata [2];
  logic [DATA_W-1:0] rd_word;

  logic              inflight;
  logic              inflight_last;
  logic [DATA_W:0]   fifo_mem [WGT_FIFO_DEPTH];
  logic              fifo_wp;
  logic              fifo_rp;
  logic [1:0]        fifo_cnt;
  logic [1:0]        occ;

  logic              wr_ok;
  logic              issue;
  logic              addr_last;
  logic              pop;
  logic              push_fifo;
  logic              pop_fifo;
  logic              feed_release;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wgt_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clock (clock),
      .we    (ram_we[b]),
      .waddr (wgt_wr_addr),
      .wdata (wgt_wr_data),
      .re    (ram_re[b]),
      .raddr (rd_addr),
      .rdata (ram_rdata[b])
    );
  end

  // The RAM output register acts as the first FIFO slot: a word returning
  // from the RAM is presented immediately and only enters fifo_mem if it is
  // not accepted in that cycle. This gives 1 word/cycle with the simple
  // occupancy < 2 credit rule.
  always_comb begin
    wr_ok        = wgt_wr_en && !bank_vld[chn_sel];
    occ          = fifo_cnt + {1'b0, inflight};
    addr_last    = ({1'b0, rd_addr} + 1'b1) == bank_len[rd_bank];
    issue        = ((state == STREAM) || (state == WAIT && bank_vld[rd_bank])) && (occ < 2'd2);
    rd_word      = ram_rdata[rd_bank];
    wgt_out_vld  = (occ != 2'd0);
    pop          = wgt_out_vld && wgt_out_rdy;
    push_fifo    = inflight && !(pop && fifo_cnt == 2'd0);
    pop_fifo     = pop && (fifo_cnt != 2'd0);
    feed_release = (state == DRAIN) && pop && (occ == 2'd1);
    feed_done    = feed_release;
    ram_we       = '0;
    ram_re       = '0;
    if (wr_ok) ram_we[chn_sel] = 1'b1;
    if (issue) ram_re[rd_bank] = 1'b1;
    if (fifo_cnt != 2'd0) begin
      {wgt_out_last, wgt_out} = fifo_mem[fifo_rp];
    end else if (inflight) begin
      {wgt_out_last, wgt_out} = {inflight_last, rd_word};
    end else begin
      {wgt_out_last, wgt_out} = '0;
    end
  end

  // Feed sequencing. WAIT issues the first read itself as soon as the bank
  // turns valid, so streaming starts two cycles after fill_done.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      rep_cnt   <= '0;
      feed_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (feed_start) begin
            rep_cnt   <= feed_repeat;
            rd_addr   <= '0;
            feed_busy <= 1'b1;
            state     <= bank_vld[rd_bank] ? STREAM : WAIT;
          end
        end
        WAIT, STREAM: begin
          if (issue) begin
            if (addr_last) begin
              rd_addr <= '0;
              if (rep_cnt == '0) begin
                state <= DRAIN;
              end else begin
                rep_cnt <= rep_cnt - 1'b1;
                state   <= STREAM;
              end
            end else begin
              rd_addr <= rd_addr + 1'b1;
              state   <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (feed_release) begin
            state     <= IDLE;
            feed_busy <= 1'b0;
            rd_bank   <= ~rd_bank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank ownership. A release and a fill_done to the same bank cannot both
  // take effect: the bank is still owned during the release cycle, so the
  // fill_done is rejected and flagged.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bank_vld    <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wr_err      <= 1'b0;
    end else begin
      if (feed_release) bank_vld[rd_bank] <= 1'b0;
      if (fill_done && !bank_vld[chn_sel]) begin
        bank_vld[chn_sel] <= 1'b1;
        bank_len[chn_sel] <= (fill_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : fill_len;
      end
      if ((wgt_wr_en || fill_done) && bank_vld[chn_sel]) wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      fifo_cnt      <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_last <= addr_last;
      if (push_fifo) fifo_wp <= ~fifo_wp;
      if (pop_fifo) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push_fifo} - {1'b0, pop_fifo};
    end
  end

  always_ff @(posedge clock) begin
    if (push_fifo) fifo_mem[fifo_wp] <= {inflight_last, rd_word};
  end

endmodule

// File: tb/tb_wgt_pingpong_feeder.sv
// Scoreboard bench for wgt_pingpong_feeder: stimulus pushes the expected word
// stream of each feed (bank contents x passes) into a queue; a monitor pops
// and compares on every accepted output word.
module tb_wgt_pingpong_feeder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic          wgt_wr_en;
  logic [AW-1:0] wgt_wr_addr;
  logic [DW-1:0] wgt_wr_data;
  logic          chn_sel;
  logic          fill_done;
  logic [AW:0]   fill_len;
  logic [1:0]    bank_vld;
  logic          feed_start;
  logic [RW-1:0] feed_repeat;
  logic          feed_busy;
  logic          feed_done;
  logic          wgt_out_vld;
  logic [DW-1:0] wgt_out;
  logic          wgt_out_last;
  logic          wgt_out_rdy;
  logic          wr_err;

  wgt_pingpong_feeder #(.DATA_W(DW), .ADDR_W(AW), .REP_W(RW)) dut (
    .clock        (clock),
    .rst          (rst),
    .wgt_wr_en    (wgt_wr_en),
    .wgt_wr_addr  (wgt_wr_addr),
    .wgt_wr_data  (wgt_wr_data),
    .chn_sel      (chn_sel),
    .fill_done    (fill_done),
    .fill_len     (fill_len),
    .bank_vld     (bank_vld),
    .feed_start   (feed_start),
    .feed_repeat  (feed_repeat),
    .feed_busy    (feed_busy),
    .feed_done    (feed_done),
    .wgt_out_vld  (wgt_out_vld),
    .wgt_out      (wgt_out),
    .wgt_out_last (wgt_out_last),
    .wgt_out_rdy  (wgt_out_rdy),
    .wr_err       (wr_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  int            exp_done = 0;
  bit            rdy_rand = 1'b0;
  logic [DW-1:0] mmem [2][256];
  int            mlen [2];
  int            m_rd_bank = 0;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    wgt_out_rdy = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      wgt_out_rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  exp_t          e;

  always @(negedge clock) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!wgt_out_vld || wgt_out !== prev_data || wgt_out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: vld=%0b data=%0h last=%0b, required vld=1 data=%0h last=%0b",
                   wgt_out_vld, wgt_out, wgt_out_last, prev_data, prev_last);
        end
      end
      checks++;
      if (wgt_out_vld && wgt_out_rdy) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=%0h last=%0b, required no transfer", wgt_out, wgt_out_last);
        end else begin
          e = sb.pop_front();
          if (wgt_out !== e.data || wgt_out_last !== e.last || feed_done !== e.fin) begin
            errors++;
            $display("FAIL word: data=%0h last=%0b done=%0b, required data=%0h last=%0b done=%0b",
                     wgt_out, wgt_out_last, feed_done, e.data, e.last, e.fin);
          end
        end
        if (feed_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end else if (feed_done !== 1'b0) begin
        errors++;
        $display("FAIL done_without_transfer: feed_done=%0b, required 0", feed_done);
      end
      prev_hold = wgt_out_vld && !wgt_out_rdy;
      prev_data = wgt_out;
      prev_last = wgt_out_last;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // kind 0: data=addr, 1: data=0x100+addr, 2: random
  task automatic fill(input int b, input int n, input int kind);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       d = DW'(i);
        1:       d = DW'(16'h100 + i);
        default: d = DW'($urandom);
      endcase
      wgt_wr_en   = 1'b1;
      chn_sel     = b[0];
      wgt_wr_addr = AW'(i);
      wgt_wr_data = d;
      mmem[b][i]  = d;
      tick();
    end
    wgt_wr_en = 1'b0;
    fill_done = 1'b1;
    chn_sel   = b[0];
    fill_len  = (n == 256) ? '0 : (AW + 1)'(n);
    mlen[b]   = n;
    tick();
    fill_done = 1'b0;
  endtask

  task automatic expect_feed(input int b, input int reps);
    exp_t x;
    for (int p = 0; p <= reps; p++) begin
      for (int i = 0; i < mlen[b]; i++) begin
        x.data = mmem[b][i];
        x.last = (i == mlen[b] - 1);
        x.fin  = (p == reps) && (i == mlen[b] - 1);
        sb.push_back(x);
      end
    end
  endtask

  task automatic start_feed(input int reps);
    feed_start  = 1'b1;
    feed_repeat = RW'(reps);
    start_cyc   = cyc;
    tick();
    feed_start  = 1'b0;
  endtask

  task automatic begin_feed(input int reps, input bit rnd, input bit lat, output int total);
    rdy_rand = rnd;
    total    = mlen[m_rd_bank] * (reps + 1);
    expect_feed(m_rd_bank, reps);
    exp_done = done_cnt + 1;
    start_feed(reps);
    if (lat) begin
      @(negedge clock);
      chk("first_vld_cycle1", 32'(wgt_out_vld), 32'd0);
      tick();
      @(negedge clock);
      chk("first_vld_cycle2", 32'(wgt_out_vld), 32'd1);
    end
  endtask

  task automatic finish_feed(input int total, input bit timed);
    for (int k = 0; k < total * 10 + 100 && done_cnt < exp_done; k++) tick();
    chk("feed_done_seen", 32'(done_cnt), 32'(exp_done));
    if (timed) chk("feed_done_timing", 32'(done_cyc - start_cyc), 32'(total + 1));
    chk("busy_after_done", 32'(feed_busy), 32'd0);
    chk("bank_released", 32'(bank_vld[m_rd_bank]), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    m_rd_bank ^= 1;
  endtask

  task automatic run_feed(input int reps, input bit rnd, input bit lat);
    int total;
    begin_feed(reps, rnd, lat, total);
    finish_feed(total, !rnd);
  endtask

  initial begin
    int total;
    int other;
    rst = 1'b1;
    wgt_wr_en = 1'b0; wgt_wr_addr = '0; wgt_wr_data = '0; chn_sel = 1'b0;
    fill_done = 1'b0; fill_len = '0; feed_start = 1'b0; feed_repeat = '0;
    repeat (3) tick();
    chk("reset_outputs", {wgt_out, 7'd0, wgt_out_last, wgt_out_vld, feed_done, feed_busy, wr_err, bank_vld}, 32'd0);
    rst = 1'b0;
    tick();

    // Single pass, data = addr, full-rate
    fill(m_rd_bank, 108, 0);
    chk("bank_vld_after_fill", 32'(bank_vld), 32'd1);
    run_feed(0, 1'b0, 1'b1);

    // Three passes
    fill(m_rd_bank, 108, 0);
    run_feed(2, 1'b0, 1'b1);

    // Random back-pressure
    fill(m_rd_bank, 108, 2);
    run_feed(0, 1'b1, 1'b0);

    // Ping-pong: fill the other bank while streaming
    other = m_rd_bank ^ 1;
    fill(m_rd_bank, 50, 2);
    begin_feed(0, 1'b1, 1'b0, total);
    fill(other, 36, 1);
    chk("other_bank_filled", 32'(bank_vld[other]), 32'd1);
    finish_feed(total, 1'b0);
    run_feed(0, 1'b0, 1'b1);
    chk("pingpong_no_wr_err", 32'(wr_err), 32'd0);

    // Start with both banks empty: WAIT until fill_done
    chk("both_banks_empty", 32'(bank_vld), 32'd0);
    rdy_rand = 1'b0;
    start_feed(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("wait_busy_no_vld", {30'd0, feed_busy, wgt_out_vld}, 32'd2);
      tick();
    end
    fill(m_rd_bank, 9, 2);
    expect_feed(m_rd_bank, 0);
    exp_done = done_cnt + 1;
    @(negedge clock);
    chk("wait_vld_cycle1", 32'(wgt_out_vld), 32'd0);
    tick();
    @(negedge clock);
    chk("wait_vld_cycle2", 32'(wgt_out_vld), 32'd1);
    finish_feed(9, 1'b0);

    // Write into the bank being streamed is dropped
    fill(m_rd_bank, 40, 2);
    begin_feed(1, 1'b1, 1'b0, total);
    repeat (3) tick();
    wgt_wr_en   = 1'b1;
    chn_sel     = m_rd_bank[0];
    wgt_wr_addr = AW'(5);
    wgt_wr_data = ~mmem[m_rd_bank][5];
    tick();
    wgt_wr_en = 1'b0;
    chk("wr_err_on_owned_write", 32'(wr_err), 32'd1);
    finish_feed(total, 1'b0);

    // Length boundaries: full depth (fill_len=0) and single word
    fill(m_rd_bank, 256, 2);
    run_feed(0, 1'b0, 1'b1);
    fill(m_rd_bank, 1, 2);
    run_feed(3, 1'b1, 1'b0);

    // Reset mid-stream
    fill(m_rd_bank, 108, 0);
    begin_feed(0, 1'b0, 1'b0, total);
    repeat (30) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", {wgt_out, 7'd0, wgt_out_last, wgt_out_vld, feed_done, feed_busy, wr_err, bank_vld}, 32'd0);
    sb.delete();
    m_rd_bank = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fresh feed from bank 0; fill_done to the same bank in its release cycle
    fill(0, 20, 2);
    begin_feed(0, 1'b0, 1'b1, total);
    repeat (19) tick();
    fill_done = 1'b1;
    chn_sel   = 1'b0;
    fill_len  = (AW + 1)'(5);
    @(negedge clock);
    chk("release_cycle_done", 32'(feed_done), 32'd1);
    tick();
    fill_done = 1'b0;
    chk("release_wins_bank_vld", 32'(bank_vld), 32'd0);
    chk("release_fill_wr_err", 32'(wr_err), 32'd1);
    chk("release_busy", 32'(feed_busy), 32'd0);
    chk("post_reset_done", 32'(done_cnt), 32'(exp_done));
    chk("final_scoreboard", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
